// File: rtl/mcmc_bram_sweeper.sv
// Read-modify-write sweep engine for the MCMC spin-lattice BRAM.
// Optional spin-flip statistics are built when MCMC_SWEEPER_FLIP_STATS_EN is defined.
module mcmc_bram_sweeper #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int SWEEP_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     n_words,
    input  logic [SWEEP_W-1:0]    n_sweeps,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    input  logic [DATA_W-1:0]     bram_dout,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [DATA_W-1:0]     req_word,
    output logic [ADDR_W-1:0]     req_idx,
    input  logic                  rsp_valid,
    input  logic [DATA_W-1:0]     rsp_word,
    input  logic [DATA_W/8-1:0]   rsp_mask,
    output logic                  busy,
    output logic                  finish,
    output logic [SWEEP_W-1:0]    sweep_cnt,
    output logic [DATA_W-1:0]     checksum,
    output logic [31:0]           flip_cnt
);

    localparam int                BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BYTES);
    localparam logic [2:0]        WAIT_LAST = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_REQ, S_RSP, S_WR, S_NEXT, S_DONE
    } state_t;

    state_t               state, state_nx;
    logic [ADDR_W-1:0]    base_q, nwords_q, idx;
    logic [SWEEP_W-1:0]   nsweeps_q, sweep_q;
    logic [2:0]           wait_cnt;
    logic [DATA_W-1:0]    word_q, rsp_word_q, csum_q;
    logic [BYTES-1:0]     rsp_mask_q;
    logic [DATA_W-1:0]    bit_mask, merged;
    logic                 degenerate, last_word, last_sweep;

    assign degenerate = (n_words == '0) || (n_sweeps == '0);
    assign last_word  = (idx == nwords_q - ADDR_W'(1));
    assign last_sweep = ((sweep_q + SWEEP_W'(1)) == nsweeps_q);

    assign bram_addr = base_q + idx * STRIDE;
    assign bram_din  = rsp_word_q;
    assign req_word  = word_q;
    assign req_idx   = idx;
    assign sweep_cnt = sweep_q;
    assign checksum  = csum_q;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign finish    = (state == S_DONE);

    always_comb begin
        bit_mask = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            bit_mask[b*8 +: 8] = {8{rsp_mask_q[b]}};
        end
    end

    // Word as it lands in memory: untouched bytes keep the value read earlier.
    assign merged = (word_q & ~bit_mask) | (rsp_word_q & bit_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        bram_en   = 1'b0;
        bram_we   = '0;
        req_valid = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = degenerate ? S_DONE : S_RD;
            end
            S_RD: begin
                bram_en  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nx = S_REQ;
            end
            S_REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_nx = S_RSP;
            end
            S_RSP: begin
                if (rsp_valid) state_nx = (rsp_mask != '0) ? S_WR : S_NEXT;
            end
            S_WR: begin
                bram_en  = 1'b1;
                bram_we  = rsp_mask_q;
                state_nx = S_NEXT;
            end
            S_NEXT: begin
                state_nx = (last_word && last_sweep) ? S_DONE : S_RD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            nwords_q   <= '0;
            nsweeps_q  <= '0;
            idx        <= '0;
            sweep_q    <= '0;
            wait_cnt   <= '0;
            word_q     <= '0;
            rsp_word_q <= '0;
            rsp_mask_q <= '0;
            csum_q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        nwords_q  <= n_words;
                        nsweeps_q <= n_sweeps;
                        idx       <= '0;
                        sweep_q   <= '0;
                        csum_q    <= '0;
                    end
                end
                S_RD: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == WAIT_LAST) word_q <= bram_dout;
                end
                S_RSP: begin
                    if (rsp_valid) begin
                        rsp_word_q <= rsp_word;
                        rsp_mask_q <= rsp_mask;
                    end
                end
                S_WR: csum_q <= csum_q ^ merged;
                S_NEXT: begin
                    if (last_word) begin
                        idx <= '0;
                        if (sweep_q != nsweeps_q) sweep_q <= sweep_q + SWEEP_W'(1);
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MCMC_SWEEPER_FLIP_STATS_EN
    logic [DATA_W-1:0] diff;
    logic [31:0]       flips, flip_q;
    logic [32:0]       flip_sum;

    assign diff = (word_q ^ rsp_word_q) & bit_mask;

    always_comb begin
        flips = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            flips = flips + 32'(diff[i]);
        end
    end

    assign flip_sum = {1'b0, flip_q} + {1'b0, flips};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flip_q <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            flip_q <= '0;
        end else if (state == S_WR) begin
            flip_q <= flip_sum[32] ? '1 : flip_sum[31:0];
        end
    end

    assign flip_cnt = flip_q;
`else
    assign flip_cnt = '0;
`endif

endmodule

// File: tb/tb_mcmc_bram_sweeper.sv
// Directed self-checking bench for mcmc_bram_sweeper (RD_LAT=2) with a BRAM model
// and a scripted update engine.
module tb_mcmc_bram_sweeper;

`ifdef MCMC_SWEEPER_FLIP_STATS_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr, n_words;
    logic [15:0] n_sweeps;
    logic [31:0] bram_addr;
    logic [63:0] bram_din, bram_dout;
    logic        bram_en;
    logic [7:0]  bram_we;
    logic        req_valid, req_ready;
    logic [63:0] req_word;
    logic [31:0] req_idx;
    logic        rsp_valid;
    logic [63:0] rsp_word;
    logic [7:0]  rsp_mask;
    logic        busy, finish;
    logic [15:0] sweep_cnt;
    logic [63:0] checksum;
    logic [31:0] flip_cnt;

    mcmc_bram_sweeper #(.DATA_W(64), .ADDR_W(32), .RD_LAT(2), .SWEEP_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .n_words(n_words), .n_sweeps(n_sweeps), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .bram_en(bram_en),
        .bram_we(bram_we), .req_valid(req_valid), .req_ready(req_ready),
        .req_word(req_word), .req_idx(req_idx), .rsp_valid(rsp_valid),
        .rsp_word(rsp_word), .rsp_mask(rsp_mask), .busy(busy), .finish(finish),
        .sweep_cnt(sweep_cnt), .checksum(checksum), .flip_cnt(flip_cnt)
    );

    always #5 clk = ~clk;

    // BRAM model: 16 words, two-cycle read latency, byte-masked writes.
    logic [63:0] mem [0:15];
    logic [63:0] pipe0 = '0, pipe1 = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_idx = '0;
    logic [63:0] ld_data = '0;
    int          en_cycles = 0, wr_cycles = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] we);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        pipe1 <= pipe0;
        if (ld_en) mem[ld_idx] <= ld_data;
        if (bram_en) begin
            en_cycles <= en_cycles + 1;
            if (bram_we != 8'h00) begin
                wr_cycles <= wr_cycles + 1;
                mem[bram_addr[6:3]] <= merge(mem[bram_addr[6:3]], bram_din, bram_we);
            end else begin
                pipe0 <= mem[bram_addr[6:3]];
            end
        end
    end
    assign bram_dout = pipe1;

    // Update engine: mode 0 xor 0xFF, 1 increment, 2 zero under mask 0x0F, 3 mask 0.
    int          mode = 0, ready_delay = 0, rsp_delay = 0;
    int          ph = 0, ecnt = 0, bad_cnt = 0, hs_cnt = 0;
    bit          seen = 1'b0;
    logic [63:0] w0;
    logic [31:0] i0;

    initial begin
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_word = '0; rsp_mask = '0;
        forever begin
            @(negedge clk);
            case (ph)
                0: if (req_valid) begin
                    if (!seen) begin
                        seen = 1'b1; w0 = req_word; i0 = req_idx; ecnt = 0;
                    end else if (req_word !== w0 || req_idx !== i0) begin
                        bad_cnt++;
                    end
                    if (ecnt >= ready_delay) begin req_ready = 1'b1; ph = 1; end
                    else ecnt++;
                end
                1: begin
                    req_ready = 1'b0; seen = 1'b0; hs_cnt++;
                    if (req_valid) bad_cnt++;
                    case (mode)
                        0:       begin rsp_word = w0 ^ 64'hFF; rsp_mask = 8'hFF; end
                        1:       begin rsp_word = w0 + 64'd1;  rsp_mask = 8'hFF; end
                        2:       begin rsp_word = '0;          rsp_mask = 8'h0F; end
                        default: begin rsp_word = ~w0;         rsp_mask = 8'h00; end
                    endcase
                    ecnt = 0;
                    if (rsp_delay == 0) begin rsp_valid = 1'b1; ph = 2; end
                    else ph = 3;
                end
                3: begin
                    ecnt++;
                    if (ecnt >= rsp_delay) begin rsp_valid = 1'b1; ph = 2; end
                end
                default: begin rsp_valid = 1'b0; ph = 0; end
            endcase
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] i, input logic [63:0] d);
        @(negedge clk); ld_en = 1'b1; ld_idx = i; ld_data = d;
        @(negedge clk); ld_en = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] n, input logic [15:0] s);
        @(negedge clk); base_addr = b; n_words = n; n_sweeps = s; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_finish(output int cyc);
        cyc = 0;
        while (!finish && cyc < 300) begin @(negedge clk); cyc++; end
        chk("finish_reached", {63'd0, finish}, 64'd1);
    endtask

    int cyc, wr0, en0, bad0, hs0;

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; n_words = '0; n_sweeps = '0;
        repeat (2) @(negedge clk);
        chk("rst_en",     {63'd0, bram_en}, 64'd0);
        chk("rst_we",     {56'd0, bram_we}, 64'd0);
        chk("rst_valid",  {63'd0, req_valid}, 64'd0);
        chk("rst_finish", {63'd0, finish}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_sweep",  {48'd0, sweep_cnt}, 64'd0);
        chk("rst_csum",   checksum, 64'd0);
        chk("rst_flip",   {32'd0, flip_cnt}, 64'd0);
        chk("rst_addr",   {32'd0, bram_addr}, 64'd0);
        rst = 1'b1;

        // Basic run: four words, xor 0xFF, 7 cycles per word at RD_LAT=2.
        load(0, 64'h1); load(1, 64'h2); load(2, 64'h3); load(3, 64'h4);
        mode = 0; ready_delay = 0; rsp_delay = 0;
        wr0 = wr_cycles; bad0 = bad_cnt; hs0 = hs_cnt;
        do_start(32'h0, 32'd4, 16'd1);
        chk("basic_busy", {63'd0, busy}, 64'd1);
        wait_finish(cyc);
        chk("basic_cycles", 64'(cyc), 64'd28);
        chk("basic_m0", mem[0], 64'hFE);
        chk("basic_m1", mem[1], 64'hFD);
        chk("basic_m2", mem[2], 64'hFC);
        chk("basic_m3", mem[3], 64'hFB);
        chk("basic_csum", checksum, 64'h04);
        chk("basic_sweep", {48'd0, sweep_cnt}, 64'd1);
        chk("basic_flip", {32'd0, flip_cnt}, FLIP ? 64'd32 : 64'd0);
        chk("basic_wr", 64'(wr_cycles - wr0), 64'd4);
        chk("basic_hs", 64'(hs_cnt - hs0), 64'd4);
        chk("basic_busy_end", {63'd0, busy}, 64'd0);

        // Multi-sweep: two words incremented over three sweeps.
        load(4, 64'h10); load(5, 64'h20);
        mode = 1; wr0 = wr_cycles;
        do_start(32'h20, 32'd2, 16'd3);
        wait_finish(cyc);
        chk("multi_cycles", 64'(cyc), 64'd42);
        chk("multi_m4", mem[4], 64'h13);
        chk("multi_m5", mem[5], 64'h23);
        chk("multi_sweep", {48'd0, sweep_cnt}, 64'd3);
        chk("multi_wr", 64'(wr_cycles - wr0), 64'd6);
        chk("multi_csum", checksum, 64'h30);
        chk("multi_flip", {32'd0, flip_cnt}, FLIP ? 64'd8 : 64'd0);

        // Backpressure: ready held off 5 cycles, response 3 cycles late.
        load(6, 64'h1234); load(7, 64'h5678);
        mode = 0; ready_delay = 5; rsp_delay = 3; wr0 = wr_cycles;
        do_start(32'h30, 32'd2, 16'd1);
        wait_finish(cyc);
        chk("bp_cycles", 64'(cyc), 64'd30);
        chk("bp_m6", mem[6], 64'h12CB);
        chk("bp_m7", mem[7], 64'h5687);
        chk("bp_wr", 64'(wr_cycles - wr0), 64'd2);
        chk("bp_csum", checksum, 64'h444C);
        chk("bp_stable", 64'(bad_cnt - bad0), 64'd0);
        ready_delay = 0; rsp_delay = 0;

        // Partial mask then zero mask.
        load(8, 64'hAAAA_AAAA_AAAA_AAAA); load(9, 64'h5555);
        mode = 2; wr0 = wr_cycles;
        do_start(32'h40, 32'd1, 16'd1);
        wait_finish(cyc);
        chk("pmask_m8", mem[8], 64'hAAAA_AAAA_0000_0000);
        chk("pmask_csum", checksum, 64'hAAAA_AAAA_0000_0000);
        chk("pmask_flip", {32'd0, flip_cnt}, FLIP ? 64'd16 : 64'd0);
        chk("pmask_wr", 64'(wr_cycles - wr0), 64'd1);
        mode = 3; wr0 = wr_cycles;
        do_start(32'h48, 32'd1, 16'd1);
        wait_finish(cyc);
        chk("zmask_m9", mem[9], 64'h5555);
        chk("zmask_wr", 64'(wr_cycles - wr0), 64'd0);
        chk("zmask_csum", checksum, 64'h0);
        chk("zmask_sweep", {48'd0, sweep_cnt}, 64'd1);

        // Degenerate starts: no BRAM access, finish the cycle after start.
        en0 = en_cycles;
        do_start(32'h0, 32'd0, 16'd5);
        wait_finish(cyc);
        chk("zero_words_cycles", 64'(cyc), 64'd0);
        do_start(32'h0, 32'd3, 16'd0);
        wait_finish(cyc);
        chk("zero_sweeps_cycles", 64'(cyc), 64'd0);
        chk("degen_en", 64'(en_cycles - en0), 64'd0);
        chk("degen_sweep", {48'd0, sweep_cnt}, 64'd0);

        // Start while busy is ignored.
        mode = 0; wr0 = wr_cycles;
        do_start(32'h0, 32'd2, 16'd1);
        repeat (2) @(negedge clk);
        do_start(32'h40, 32'd5, 16'd4);
        wait_finish(cyc);
        chk("busy_m0", mem[0], 64'h01);
        chk("busy_m1", mem[1], 64'h02);
        chk("busy_m8", mem[8], 64'hAAAA_AAAA_0000_0000);
        chk("busy_wr", 64'(wr_cycles - wr0), 64'd2);
        chk("busy_sweep", {48'd0, sweep_cnt}, 64'd1);
        chk("busy_csum", checksum, 64'h03);

        // Reset during the write of word 1, then rerun from idx 0.
        load(2, 64'h7);
        wr0 = wr_cycles;
        do_start(32'h0, 32'd3, 16'd1);
        cyc = 0;
        while (!(bram_we != 8'h00 && bram_addr == 32'h8) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        chk("wr1_reached", {63'd0, bram_we != 8'h00}, 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_en",    {63'd0, bram_en}, 64'd0);
        chk("mid_rst_we",    {56'd0, bram_we}, 64'd0);
        chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
        chk("mid_rst_csum",  checksum, 64'd0);
        chk("mid_rst_idx",   {32'd0, req_idx}, 64'd0);
        chk("mid_rst_din",   bram_din, 64'd0);
        @(negedge clk);
        chk("mid_rst_m1",    mem[1], 64'h02);
        chk("mid_rst_wr",    64'(wr_cycles - wr0), 64'd1);
        rst = 1'b1;
        do_start(32'h0, 32'd3, 16'd1);
        wait_finish(cyc);
        chk("rerun_m0", mem[0], 64'h01);
        chk("rerun_m1", mem[1], 64'hFD);
        chk("rerun_m2", mem[2], 64'hF8);
        chk("rerun_csum", checksum, 64'h04);
        chk("rerun_sweep", {48'd0, sweep_cnt}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
